stream_rr_arbiter: RTL and testbench

//   Round-robin burst arbiter that merges N 16-bit producer streams (avail/read

---
 rtl/stream_rr_arbiter_if.sv | 40 ++++
 rtl/stream_rr_arbiter.sv | 118 +++++++++++
 tb/tb_stream_rr_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/stream_rr_arbiter_if.sv
// rtl/stream_rr_arbiter_if.sv - producer/consumer stream bundle for the round-robin arbiter
interface stream_rr_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16
);
    localparam int SELW = $clog2(N > 1 ? N : 2);

    logic [N*WIDTH-1:0] src_data;
    logic [N-1:0]       src_avail;
    logic [N-1:0]       src_read;
    logic [WIDTH-1:0]   dst_data;
    logic               dst_write;
    logic               dst_full;
    logic [SELW-1:0]    grant_id;
    logic               running;

    // Arbiter side
    modport master (
        input  src_data,
        input  src_avail,
        input  dst_full,
        output src_read,
        output dst_data,
        output dst_write,
        output grant_id,
        output running
    );

    // Environment side: sources and consumer
    modport slave (
        output src_data,
        output src_avail,
        output dst_full,
        input  src_read,
        input  dst_data,
        input  dst_write,
        input  grant_id,
        input  running
    );
endinterface

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - round-robin burst arbiter merging N source streams into one
module stream_rr_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_rr_arbiter_if.master  bus
);
    localparam int SELW = $clog2(N > 1 ? N : 2);
    localparam int CNTW = $clog2(BURST + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SELW-1:0] r_gnt;
    logic [SELW-1:0] w_gnt_nxt;
    logic [SELW-1:0] r_rr_ptr;
    logic [SELW-1:0] w_rr_ptr_nxt;
    logic [CNTW-1:0] r_bcnt;
    logic [CNTW-1:0] w_bcnt_nxt;

    logic [SELW-1:0] w_pick;
    logic            w_found;
    logic [SELW-1:0] w_gnt_inc;
    logic            w_avail_gnt;
    logic            w_xfer;
    logic            w_last;

    assign w_avail_gnt = bus.src_avail[r_gnt];
    // Reset gates the transfer so a pop can never happen without its push.
    assign w_xfer      = (r_state == S_BUSY) & w_avail_gnt & ~bus.dst_full & ~rst;
    assign w_last      = (r_bcnt == CNTW'(BURST - 1));
    assign w_gnt_inc   = (r_gnt == SELW'(N - 1)) ? '0 : r_gnt + SELW'(1);

    // Search for the first requesting source starting at rr_ptr, wrapping mod N
    always_comb begin
        logic [SELW:0]   v_sum;
        logic [SELW-1:0] v_idx;
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        v_sum   = '0;
        v_idx   = '0;
        for (int k = 0; k < N; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (SELW + 1)'(k);
            if (v_sum >= (SELW + 1)'(N)) begin
                v_sum = v_sum - (SELW + 1)'(N);
            end
            v_idx = v_sum[SELW-1:0];
            if (!w_found && bus.src_avail[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end
        end
    end

    // Next-state logic: grant in IDLE, count and release in BUSY
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_rr_ptr_nxt = r_rr_ptr;
        w_bcnt_nxt   = r_bcnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt   = w_pick;
                    w_bcnt_nxt  = '0;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_xfer) begin
                    w_bcnt_nxt = r_bcnt + CNTW'(1);
                end
                // A drained source releases even while the consumer is full.
                if (!w_avail_gnt || (w_xfer && w_last)) begin
                    w_state_nxt  = S_IDLE;
                    w_rr_ptr_nxt = w_gnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= '0;
            r_bcnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_bcnt   <= w_bcnt_nxt;
        end
    end

    // Pop only the granted source, in the same cycle as the push
    always_comb begin
        bus.src_read        = '0;
        bus.src_read[r_gnt] = w_xfer;
    end

    assign bus.dst_data  = bus.src_data[r_gnt*WIDTH +: WIDTH];
    assign bus.dst_write = w_xfer;
    assign bus.grant_id  = r_gnt;
    assign bus.running   = (r_state == S_BUSY) | (|bus.src_avail);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - scoreboard bench for stream_rr_arbiter
module tb_stream_rr_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_rr_arbiter_if #(.N(N), .WIDTH(W)) bus ();

    stream_rr_arbiter #(.N(N), .WIDTH(W), .BURST(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] src_q [N][$];
    logic [15:0] sb [$];
    int          wr_cyc [$];
    int          next_seq [N] = '{default: 0};
    int          exp_seq  [N] = '{default: 0};
    int          total    = 0;
    int          bad      = 0;
    int          wr_count = 0;
    int          cyc      = 0;
    logic [15:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            bus.src_avail[i]       = (src_q[i].size() != 0);
            bus.src_data[i*W +: W] = (src_q[i].size() != 0) ? src_q[i][0] : 16'h0000;
        end
    endtask

    // Words are tagged {source, sequence} so order and origin are both visible
    task automatic load(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            src_q[s].push_back({s[3:0], next_seq[s][11:0]});
            next_seq[s]++;
        end
        refresh();
    endtask

    task automatic exp_words(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            sb.push_back({s[3:0], exp_seq[s][11:0]});
            exp_seq[s]++;
        end
    endtask

    task automatic wait_writes(input int target);
        for (int k = 0; k < 3000 && wr_count < target; k++) @(posedge clk);
        #2;
        chk("reach_writes", 32'(wr_count >= target), 32'd1);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 3000 && sb.size() != 0; k++) @(posedge clk);
        chk("drain_timeout", sb.size(), 0);
        repeat (4) @(posedge clk);
        #2;
        chk("idle_running", bus.running, 1'b0);
        chk("idle_write", bus.dst_write, 1'b0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Source model: pop what the DUT read, then present the next head word
    initial begin
        logic [N-1:0] pop;
        forever begin
            @(negedge clk);
            pop = bus.src_read;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (pop[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            end
            refresh();
        end
    end

    // Monitor: compare every consumer write against the scoreboard
    always @(negedge clk) begin
        chk("read_matches_write", 32'(bus.src_read),
            bus.dst_write ? (32'd1 << bus.grant_id) : 32'd0);
        if (bus.dst_write === 1'b1) begin
            if (sb.size() == 0) begin
                chk("write_without_expect", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                chk("data", bus.dst_data, mon_e);
                chk("grant", bus.grant_id, mon_e[15:12]);
                chk("running_on_write", bus.running, 1'b1);
            end
            wr_count++;
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        int base;
        rst          = 1'b1;
        bus.dst_full = 1'b0;

        // Reset with every source pending; these words then feed the all-sources test
        for (int s = 0; s < N; s++) begin
            load(s, 8);
            exp_words(s, 8);
        end
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("rst_read", bus.src_read, 4'b0000);
            chk("rst_write", bus.dst_write, 1'b0);
            chk("rst_grant", bus.grant_id, 2'd0);
            chk("rst_running", bus.running, 1'b1);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        wait_done();

        // Drain release: src 0 short, src 3 long
        load(0, 3);
        load(3, 10);
        exp_words(0, 3);
        exp_words(3, 10);
        wait_done();

        // Pointer must have wrapped to 0 after src 3
        load(3, 1);
        load(0, 1);
        exp_words(0, 1);
        exp_words(3, 1);
        wait_done();

        // Single source, 20 words: bursts 8/8/4 with one idle cycle between
        wr_cyc.delete();
        load(2, 20);
        exp_words(2, 20);
        wait_done();
        chk("t2_count", wr_cyc.size(), 20);
        if (wr_cyc.size() == 20) begin
            chk("burst1_span", wr_cyc[7] - wr_cyc[0], 7);
            chk("gap1", wr_cyc[8] - wr_cyc[7], 2);
            chk("burst2_span", wr_cyc[15] - wr_cyc[8], 7);
            chk("gap2", wr_cyc[16] - wr_cyc[15], 2);
            chk("burst3_span", wr_cyc[19] - wr_cyc[16], 3);
        end

        // Backpressure mid-burst on src 1; src 2 must wait for all 8
        load(1, 8);
        load(2, 2);
        exp_words(1, 8);
        exp_words(2, 2);
        base = wr_count;
        wait_writes(base + 3);
        bus.dst_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_read", bus.src_read, 4'b0000);
            chk("stall_write", bus.dst_write, 1'b0);
            chk("stall_grant", bus.grant_id, 2'd1);
        end
        @(posedge clk);
        #2;
        bus.dst_full = 1'b0;
        wait_done();

        // Reset after 4 words from src 1; src 0 is pending and wins afterwards
        load(1, 8);
        exp_words(1, 4);
        base = wr_count;
        wait_writes(base + 4);
        rst = 1'b1;
        load(0, 3);
        exp_words(0, 3);
        exp_words(1, 4);
        @(posedge clk);
        #2;
        rst = 1'b0;
        wait_done();
        chk("final_write_total", wr_count, 32 + 13 + 2 + 20 + 10 + 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
